// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, word/key types, GF(2^8) doubling and the byte S-box.
package aes_pkg;
    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    // S-box entries packed MSB-first: entry 0x00 occupies bits [2047:2040].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX_TABLE[base +: 8];
    endfunction
endpackage

// File: rtl/key_expand_step.sv
// One AES-128 key-expansion round: derives the next round key from the current one.
module key_expand_step
    import aes_pkg::*;
(
    input  key_t  cur_key,
    input  word_t rcon_word,
    output key_t  nxt_key
);
    word_t w0, w1, w2, w3;
    word_t rot, sub, t;
    word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = cur_key;
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign t   = sub ^ rcon_word;

    assign n0 = w0 ^ t;
    assign n1 = n0 ^ w1;
    assign n2 = n1 ^ w2;
    assign n3 = n2 ^ w3;

    assign nxt_key = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one expansion step reused over NR cycles,
// round keys kept in a register file and served by index with one cycle of read latency.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter bit ZEROIZE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         clear,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;
    localparam logic [3:0] LAST      = 4'(NR);

    logic [0:0] state;
    logic [3:0] round;
    logic [7:0] rcon;
    key_t       cur_key;
    key_t       nxt_key;
    key_t       key_mem [NR+1];

    key_expand_step u_step (
        .cur_key   (cur_key),
        .rcon_word ({rcon, 24'h000000}),
        .nxt_key   (nxt_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            round      <= 4'd0;
            rcon       <= RCON_INIT;
            cur_key    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rd_key     <= '0;
            for (int i = 0; i <= NR; i++) begin
                key_mem[i] <= '0;
            end
        end else begin
            done   <= 1'b0;
            rd_key <= (rd_idx <= LAST) ? key_mem[rd_idx] : '0;
            case (state)
                ST_IDLE: begin
                    // start takes priority over clear; both wipe stale round keys when zeroizing
                    if (start) begin
                        if (ZEROIZE) begin
                            for (int i = 1; i <= NR; i++) begin
                                key_mem[i] <= '0;
                            end
                        end
                        key_mem[0] <= key_in;
                        cur_key    <= key_in;
                        round      <= 4'd1;
                        rcon       <= RCON_INIT;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                        state      <= ST_EXPAND;
                    end else if (clear) begin
                        if (ZEROIZE) begin
                            for (int i = 0; i <= NR; i++) begin
                                key_mem[i] <= '0;
                            end
                        end
                        keys_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    key_mem[round] <= nxt_key;
                    cur_key        <= nxt_key;
                    rcon           <= xtime(rcon);
                    round          <= round + 4'd1;
                    if (round == LAST) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl against a GF(2^8)-arithmetic key-schedule model.
module tb_aes_key_sched_ctrl;
    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst, start, clear;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic         busy, done, keys_valid;
    logic [127:0] rd_key;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int mon_exp_cycle;
    logic [127:0] mon_exp_key;
    logic         rd_req  = 1'b0;
    logic         rd_pend = 1'b0;
    logic [127:0] exp_rd_q [$];
    int           exp_done_q [$];
    logic [127:0] exp_mem [16];

    aes_key_sched_ctrl #(.NR(NR), .ZEROIZE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .clear      (clear),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle   <= cycle + 1;
        rd_pend <= rd_req;
    end

    // Reference model: plain GF(2^8) arithmetic and the FIPS-197 word recurrence
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow2(input int n);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < n; i++) p = gf_mul(p, 8'h02);
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] expand_model(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        for (int i = 4; i < 4 * (r + 1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_model(t[31:24]), sbox_model(t[23:16]), sbox_model(t[15:8]), sbox_model(t[7:0])}
                    ^ {gf_pow2(i / 4 - 1), 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops read and done expectations whenever the DUT presents a response
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_orphan: got %h, required no pending read", rd_key);
            end else begin
                mon_exp_key = exp_rd_q.pop_front();
                check_output("rd_key", rd_key, mon_exp_key);
            end
        end
        if (done) begin
            checks++;
            if (exp_done_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL done_unexpected: got done=1 at cycle %0d, required 0", cycle);
            end else begin
                mon_exp_cycle = exp_done_q.pop_front();
                if (mon_exp_cycle != cycle) begin
                    errors++;
                    $display("[TB] FAIL done_latency: got cycle %0d, required %0d", cycle, mon_exp_cycle);
                end
            end
            check_output("valid_with_done", keys_valid, 1);
            check_output("busy_with_done", busy, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_model(input logic [127:0] k);
        for (int i = 0; i < 16; i++) exp_mem[i] = (i <= NR) ? expand_model(k, i) : '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    endtask

    task automatic apply_stimulus(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        exp_done_q.push_back(cycle + 1 + NR);
        tick();
        start  = 1'b0;
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic read_key(input int idx, input logic [127:0] exp);
        exp_rd_q.push_back(exp);
        rd_idx = 4'(idx);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        int off;
        off = $urandom_range(0, 15);
        for (int n = 0; n < 16; n++) read_key((off + n) % 16, exp_mem[(off + n) % 16]);
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        #1;
        while (exp_done_q.size() != 0 && n < budget) begin
            tick();
            #1;
            n++;
        end
        if (exp_done_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done within %0d cycles, required done", budget);
            exp_done_q.delete();
        end
    endtask

    initial begin
        logic [127:0] k;
        int cnt;
        rst    = 1'b1;
        start  = 1'b0;
        clear  = 1'b0;
        key_in = '0;
        rd_idx = '0;
        idle(2);
        rst = 1'b0;
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_valid", keys_valid, 0);
        check_output("reset_rd_key", rd_key, 0);
        clear_model();
        read_all();

        $display("[TB] FIPS-197 expansion and rcon sequence");
        set_model(FIPS_KEY);
        apply_stimulus(FIPS_KEY);
        cnt = 0;
        while (busy && cnt < NR + 4) begin
            check_output("rcon", dut.rcon, gf_pow2(cnt));
            cnt++;
            tick();
        end
        check_output("busy_cycles", cnt, NR);
        wait_done(20);
        check_output("valid_after_fips", keys_valid, 1);
        read_key(1, FIPS_RK1);
        read_key(10, FIPS_RK10);
        read_all();

        $display("[TB] start while busy");
        apply_stimulus(FIPS_KEY);
        idle(2);
        start  = 1'b1;
        key_in = '0;
        tick();
        start  = 1'b0;
        wait_done(20);
        idle(4);
        read_key(10, FIPS_RK10);
        read_all();

        $display("[TB] reset mid-expansion");
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(k);
        idle(4);
        check_output("round_at_rst", dut.round, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_done_q.delete();
        clear_model();
        check_output("rst_busy", busy, 0);
        check_output("rst_valid", keys_valid, 0);
        check_output("rst_rd_key", rd_key, 0);
        read_all();
        idle(NR + 3);

        $display("[TB] random keys");
        for (int r = 0; r < 3; r++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_model(k);
            apply_stimulus(k);
            wait_done(20);
            check_output("valid_random", keys_valid, 1);
            read_all();
        end

        $display("[TB] back-to-back start and clear");
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(k);
        wait_done(20);
        check_output("done_in_b2b_cycle", done, 1);
        set_model('0);
        apply_stimulus('0);
        wait_done(20);
        read_key(10, ZERO_RK10);
        read_all();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        clear_model();
        check_output("clear_valid", keys_valid, 0);
        read_all();

        $display("[TB] clear with start, then out-of-range reads");
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        set_model(k);
        clear = 1'b1;
        apply_stimulus(k);
        clear = 1'b0;
        wait_done(20);
        read_key(10, exp_mem[10]);
        for (int i = 11; i < 16; i++) read_key(i, '0);
        read_key(0, k);
        read_key(15, '0);
        read_key(4, exp_mem[4]);
        idle(3);

        if (exp_rd_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rd_leftover: got %0d unserved reads, required 0", exp_rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
